// File: rtl/multi_clk_gen_pkg.sv
// rtl/multi_clk_gen_pkg.sv - shared types and helpers for the NCO clock-enable synthesiser
package multi_clk_gen_pkg;

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam int CHAN_W = 4;

  // Rounded NCO increment for f_out from f_ref with an acc_w-bit accumulator.
  function automatic longint unsigned inc_for(input longint unsigned f_ref_hz,
                                              input longint unsigned f_out_hz,
                                              input int acc_w);
    return ((f_out_hz << acc_w) + (f_ref_hz >> 1)) / f_ref_hz;
  endfunction

endpackage

// File: rtl/clk_nco_chan.sv
// rtl/clk_nco_chan.sv - one phase-accumulator channel producing an enable pulse and square wave
module clk_nco_chan #(
  parameter int               ACC_W   = 24,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [ACC_W-1:0] load_inc,
  output logic             en,
  output logic             sq
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      inc <= INC_RST;
      en  <= 1'b0;
      sq  <= 1'b0;
    end else begin
      if (load)
        inc <= load_inc;
      // A reload or global align restarts the phase from zero.
      if (load || clear) begin
        acc <= '0;
        en  <= 1'b0;
        sq  <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        en  <= sum[ACC_W];
        sq  <= sum[ACC_W-1];
      end
    end
  end

endmodule

// File: rtl/multi_clk_en_synth.sv
// rtl/multi_clk_en_synth.sv - NUM_CLOCKS NCO clock-enable generator with runtime config and lock
module multi_clk_en_synth
  import multi_clk_gen_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_INIT =
    {NUM_CLOCKS{ACC_W'(inc_for(64'd50_000_000, 64'd10_000_000, ACC_W))}}
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [ACC_W-1:0]      cfg_inc,
  output logic                  cfg_err,
  input  logic                  sync_all,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int                CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CHAN_W:0]   NUM_CH   = (CHAN_W + 1)'(NUM_CLOCKS);

  lock_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cfg_fire;
  logic             chan_ok;
  logic             cfg_load;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign chan_ok  = ({1'b0, cfg_chan} < NUM_CH);
  assign cfg_load = cfg_fire & chan_ok;
  assign locked   = (state == LOCKED);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= SETTLE;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cfg_ready <= 1'b1;
      cfg_err   <= cfg_fire & ~chan_ok;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      SETTLE: begin
        if (cnt == CNT_LAST)
          state_n = LOCKED;
        else
          cnt_n = cnt + CNT_W'(1);
      end
      LOCKED: ;
      default: state_n = SETTLE;
    endcase
    // Retuning any channel restarts the settle window, even on its terminal count.
    if (cfg_load) begin
      state_n = SETTLE;
      cnt_n   = '0;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    clk_nco_chan #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
    ) u_chan (
      .refclk   (refclk),
      .rst      (rst),
      .load     (cfg_load && (cfg_chan == CHAN_W'(i))),
      .clear    (sync_all),
      .load_inc (cfg_inc),
      .en       (outclk_en[i]),
      .sq       (outclk[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_en_synth.sv
// tb/tb_multi_clk_en_synth.sv - randomized bench against a phase-arithmetic reference model
module tb_multi_clk_en_synth;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int LC = 16;
  localparam longint unsigned MOD  = 64'd1 << AW;
  localparam longint unsigned HALF = 64'd1 << (AW - 1);
  localparam longint unsigned INIT_INC = 64'd3355443;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_chan;
  logic [AW-1:0] cfg_inc;
  logic          cfg_err;
  logic          sync_all;
  logic [N-1:0]  outclk_en;
  logic [N-1:0]  outclk;
  logic          locked;

  multi_clk_en_synth dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .cfg_err   (cfg_err),
    .sync_all  (sync_all),
    .outclk_en (outclk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int n_chk  = 0;
  int n_pass = 0;

  longint unsigned ph[N];
  longint unsigned inc_m[N];
  logic [N-1:0]    m_en;
  logic [N-1:0]    m_sq;
  int              edges;
  logic            m_err;
  logic            m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i]    = 0;
      inc_m[i] = INIT_INC;
    end
    m_en = '0; m_sq = '0; edges = 0; m_err = 1'b0; m_ready = 1'b0;
  endtask

  // One refclk edge: advance the model from the inputs in force, then compare outputs.
  task automatic step();
    logic fire, ok;
    longint unsigned s;
    @(posedge refclk);
    fire = cfg_valid && m_ready;
    ok   = (cfg_chan < N);
    for (int i = 0; i < N; i++) begin
      if (sync_all || (fire && ok && cfg_chan == i)) begin
        if (fire && ok && cfg_chan == i) inc_m[i] = cfg_inc;
        ph[i] = 0; m_en[i] = 1'b0; m_sq[i] = 1'b0;
      end else begin
        s       = ph[i] + inc_m[i];
        m_en[i] = (s >= MOD);
        ph[i]   = s % MOD;
        m_sq[i] = (ph[i] >= HALF);
      end
    end
    m_err   = fire && !ok;
    edges   = (fire && ok) ? 0 : ((edges < 1000000) ? edges + 1 : edges);
    m_ready = 1'b1;
    #1;
    check("outclk_en", 32'(outclk_en), 32'(m_en));
    check("outclk",    32'(outclk),    32'(m_sq));
    check("locked",    32'(locked),    32'(edges >= LC));
    check("cfg_err",   32'(cfg_err),   32'(m_err));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic cfg(input int ch, input longint unsigned inc);
    cfg_valid = 1'b1; cfg_chan = 4'(ch); cfg_inc = AW'(inc);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},     32'(outclk_en), 32'd0);
    check({tag, "_clk"},    32'(outclk),    32'd0);
    check({tag, "_locked"}, 32'(locked),    32'd0);
    check({tag, "_ready"},  32'(cfg_ready), 32'd0);
    check({tag, "_err"},    32'(cfg_err),   32'd0);
  endtask

  initial begin
    int c0, c1, c2, d;
    logic prev;
    rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; sync_all = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    // Lock after reset, then default ch0 rate.
    for (int k = 1; k <= LC; k++) step();
    check("lock_edge16", 32'(locked), 32'd1);
    c0 = 0;
    for (int k = 0; k < 500; k++) begin step(); if (outclk_en[0]) c0++; end
    check("ch0_500cyc_ge99",  32'(c0 >= 99),  32'd1);
    check("ch0_500cyc_le101", 32'(c0 <= 101), 32'd1);

    // ch1 retune to 2^22: divide-by-4 with 2/2 duty.
    cfg(1, 64'd1 << 22);
    check("lock_drop_cfg", 32'(locked), 32'd0);
    c1 = 0; c2 = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (outclk_en[1]) c1++;
      if (outclk[1]) c2++;
    end
    check("ch1_pulses", 32'(c1), 32'd10);
    check("ch1_high",   32'(c2), 32'd20);
    check("relock",     32'(locked), 32'd1);

    // Invalid channel: error pulse only.
    cfg(9, 64'd12345);
    check("err_pulse", 32'(cfg_err), 32'd1);
    check("err_lock",  32'(locked),  32'd1);
    step();
    check("err_clear", 32'(cfg_err), 32'd0);

    // Frozen channel.
    cfg(2, 0);
    c2 = 0; d = 0; prev = outclk[2];
    for (int k = 0; k < 1000; k++) begin
      step();
      if (outclk_en[2]) c2++;
      if (outclk[2] != prev) d++;
      prev = outclk[2];
    end
    check("ch2_no_pulse", 32'(c2), 32'd0);
    check("ch2_static",   32'(d),  32'd0);

    // Phase align two channels that were loaded two cycles apart.
    cfg(0, 64'd1 << 22);
    step();
    cfg(1, 64'd1 << 22);
    for (int k = 0; k < 20; k++) step();
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    c0 = 0; c1 = 0; d = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (outclk_en[0] != outclk_en[1]) c1++;
      if (outclk_en[0]) c0++;
      if (!locked) d++;
    end
    check("align_diff",  32'(c1), 32'd0);
    check("align_rate",  32'(c0), 32'd10);
    check("align_nodrop", 32'(d), 32'd0);

    // Asynchronous reset five cycles into a settle window.
    cfg(3, 64'd1 << 23);
    for (int k = 0; k < 5; k++) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge refclk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= LC - 1; k++) step();
    check("rst_lock15", 32'(locked), 32'd0);
    step();
    check("rst_lock16", 32'(locked), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cfg_valid = ($urandom_range(0, 59) == 0);
      cfg_chan  = 4'($urandom_range(0, 5) < 5 ? $urandom_range(0, N - 1) : $urandom_range(N, 15));
      case ($urandom_range(0, 3))
        0:       cfg_inc = '0;
        1:       cfg_inc = AW'(64'd1 << 22);
        2:       cfg_inc = AW'($urandom());
        default: cfg_inc = AW'($urandom()) | AW'(HALF);
      endcase
      sync_all = ($urandom_range(0, 49) == 0);
      step();
    end
    cfg_valid = 1'b0; sync_all = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
